// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry block: key codes, debounce state
// encoding and the default debounce interval.
package keypad_pkg;

    localparam logic [3:0] KEY_0 = 4'h0;
    localparam logic [3:0] KEY_1 = 4'h1;
    localparam logic [3:0] KEY_2 = 4'h2;
    localparam logic [3:0] KEY_3 = 4'h3;
    localparam logic [3:0] KEY_4 = 4'h4;
    localparam logic [3:0] KEY_5 = 4'h5;
    localparam logic [3:0] KEY_6 = 4'h6;
    localparam logic [3:0] KEY_7 = 4'h7;
    localparam logic [3:0] KEY_8 = 4'h8;
    localparam logic [3:0] KEY_9 = 4'h9;
    localparam logic [3:0] KEY_A = 4'hA;
    localparam logic [3:0] KEY_B = 4'hB;
    localparam logic [3:0] KEY_C = 4'hC;
    localparam logic [3:0] KEY_D = 4'hD;
    localparam logic [3:0] KEY_E = 4'hE;
    localparam logic [3:0] KEY_F = 4'hF;

    localparam logic [3:0] KEY_ENTER = KEY_E;
    localparam logic [3:0] KEY_CLEAR = KEY_C;
    localparam logic [3:0] KEY_BACK  = KEY_F;

    // 5 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

    typedef enum logic [1:0] {
        ST_RELEASED,
        ST_PRESS_WAIT,
        ST_PRESSED,
        ST_RELEASE_WAIT
    } deb_state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_9;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Press/release debouncer: one registered key_strobe per accepted press, with
// key_value holding the code sampled on the accepting cycle.
module key_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_code,
    input  logic       key_down,
    output logic       key_strobe,
    output logic [3:0] key_value
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    deb_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          key_strobe_q, key_strobe_d;
    logic [3:0]    key_value_q, key_value_d;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_strobe_d = 1'b0;
        key_value_d  = key_value_q;
        case (state_q)
            ST_RELEASED: begin
                if (key_down) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            ST_PRESS_WAIT: begin
                if (!key_down) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    // This high cycle brings the count to DEBOUNCE_CYCLES.
                    state_d      = ST_PRESSED;
                    cnt_d        = cnt_inc;
                    key_strobe_d = 1'b1;
                    key_value_d  = key_code;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_PRESSED: begin
                if (!key_down) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            ST_RELEASE_WAIT: begin
                if (key_down) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RELEASED;
            cnt_q        <= '0;
            key_strobe_q <= 1'b0;
            key_value_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_strobe_q <= key_strobe_d;
            key_value_q  <= key_value_d;
        end
    end

    assign key_strobe = key_strobe_q;
    assign key_value  = key_value_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: debounced key strobes feed a BCD entry buffer with
// backspace/clear/enter editing and a valid/ready hand-off of committed entries.
module keypad_entry #(
    parameter int         NUM_DIGITS      = 4,
    parameter int         DEBOUNCE_CYCLES = keypad_pkg::DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [3:0] KEY_ENTER       = keypad_pkg::KEY_ENTER,
    parameter logic [3:0] KEY_CLEAR       = keypad_pkg::KEY_CLEAR,
    parameter logic [3:0] KEY_BACK        = keypad_pkg::KEY_BACK
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [3:0]                        key_code,
    input  logic                              key_down,
    output logic                              key_strobe,
    output logic [3:0]                        key_value,
    output logic [4*NUM_DIGITS-1:0]           live_value,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   live_len,
    output logic [4*NUM_DIGITS-1:0]           entry_value,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   entry_len,
    output logic                              entry_valid,
    input  logic                              entry_ready
);

    import keypad_pkg::*;

    localparam int VW = 4 * NUM_DIGITS;
    localparam int LW = $clog2(NUM_DIGITS + 1);
    localparam logic [LW-1:0] MAX_LEN = LW'(NUM_DIGITS);

    logic [VW-1:0] live_value_q, live_value_d;
    logic [LW-1:0] live_len_q, live_len_d;
    logic [VW-1:0] entry_value_q, entry_value_d;
    logic [LW-1:0] entry_len_q, entry_len_d;
    logic          entry_valid_q, entry_valid_d;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .key_code  (key_code),
        .key_down  (key_down),
        .key_strobe(key_strobe),
        .key_value (key_value)
    );

    always_comb begin
        live_value_d  = live_value_q;
        live_len_d    = live_len_q;
        entry_value_d = entry_value_q;
        entry_len_d   = entry_len_q;
        entry_valid_d = entry_valid_q;

        if (entry_valid_q && entry_ready) begin
            entry_valid_d = 1'b0;
        end

        // Keys are dropped while an entry is pending, including its accept cycle.
        if (key_strobe && !entry_valid_q) begin
            if (is_digit(key_value)) begin
                if (live_len_q < MAX_LEN) begin
                    live_value_d = (live_value_q << 4) | VW'(key_value);
                    live_len_d   = live_len_q + LW'(1);
                end
            end else if (key_value == KEY_BACK) begin
                if (live_len_q != '0) begin
                    live_value_d = live_value_q >> 4;
                    live_len_d   = live_len_q - LW'(1);
                end
            end else if (key_value == KEY_CLEAR) begin
                live_value_d = '0;
                live_len_d   = '0;
            end else if (key_value == KEY_ENTER) begin
                if (live_len_q != '0) begin
                    entry_value_d = live_value_q;
                    entry_len_d   = live_len_q;
                    entry_valid_d = 1'b1;
                    live_value_d  = '0;
                    live_len_d    = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            live_value_q  <= '0;
            live_len_q    <= '0;
            entry_value_q <= '0;
            entry_len_q   <= '0;
            entry_valid_q <= 1'b0;
        end else begin
            live_value_q  <= live_value_d;
            live_len_q    <= live_len_d;
            entry_value_q <= entry_value_d;
            entry_len_q   <= entry_len_d;
            entry_valid_q <= entry_valid_d;
        end
    end

    assign live_value  = live_value_q;
    assign live_len    = live_len_q;
    assign entry_value = entry_value_q;
    assign entry_len   = entry_len_q;
    assign entry_valid = entry_valid_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry with a short debounce interval; each task
// drives one scenario and compares outputs against hand-computed values.
module tb_keypad_entry;

    localparam int ND = 4;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  key_code = 4'h0;
    logic        key_down = 1'b0;
    logic        entry_ready = 1'b1;
    logic        key_strobe;
    logic [3:0]  key_value;
    logic [15:0] live_value;
    logic [2:0]  live_len;
    logic [15:0] entry_value;
    logic [2:0]  entry_len;
    logic        entry_valid;

    int checks = 0;
    int failures = 0;
    int strobe_cnt = 0;
    int valid_cycles = 0;
    logic [15:0] mon_value = '0;
    logic [2:0]  mon_len = '0;

    keypad_entry #(
        .NUM_DIGITS     (ND),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_code   (key_code),
        .key_down   (key_down),
        .key_strobe (key_strobe),
        .key_value  (key_value),
        .live_value (live_value),
        .live_len   (live_len),
        .entry_value(entry_value),
        .entry_len  (entry_len),
        .entry_valid(entry_valid),
        .entry_ready(entry_ready)
    );

    always #5 clk = ~clk;

    // Event monitors sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (key_strobe === 1'b1) strobe_cnt = strobe_cnt + 1;
        if (entry_valid === 1'b1) begin
            valid_cycles = valid_cycles + 1;
            mon_value    = entry_value;
            mon_len      = entry_len;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [3:0] code);
        key_code = code;
        key_down = 1'b1;
        cycles(DC + 2);
        key_down = 1'b0;
        cycles(DC + 2);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cycles(2);
        checks++;
        if (key_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe: got %b expected 0", key_strobe); end
        checks++;
        if (key_value !== 4'h0) begin failures++; $display("FAIL reset_key_value: got %h expected 0", key_value); end
        checks++;
        if (live_value !== 16'h0 || live_len !== 3'd0) begin
            failures++; $display("FAIL reset_live: got %h/%0d expected 0000/0", live_value, live_len);
        end
        checks++;
        if (entry_value !== 16'h0 || entry_len !== 3'd0 || entry_valid !== 1'b0) begin
            failures++; $display("FAIL reset_entry: got %h/%0d/%b expected 0000/0/0", entry_value, entry_len, entry_valid);
        end
        reset = 1'b0;
        cycles(1);
    endtask

    task automatic test_bounce;
        int s0;
        s0 = strobe_cnt;
        key_code = 4'h5;
        key_down = 1'b1; cycles(DC - 1);
        key_down = 1'b0; cycles(1);
        key_down = 1'b1; cycles(DC - 1);
        key_down = 1'b0; cycles(DC + 2);
        checks++;
        if (strobe_cnt - s0 !== 0) begin failures++; $display("FAIL bounce_strobes: got %0d expected 0", strobe_cnt - s0); end
        checks++;
        if (live_len !== 3'd0) begin failures++; $display("FAIL bounce_live_len: got %0d expected 0", live_len); end
    endtask

    task automatic test_single_press;
        int s0;
        s0 = strobe_cnt;
        key_code = 4'h5;
        key_down = 1'b1;
        cycles(DC);
        checks++;
        if (key_strobe !== 1'b1 || key_value !== 4'h5) begin
            failures++; $display("FAIL single_strobe: got %b/%h expected 1/5", key_strobe, key_value);
        end
        cycles(1);
        checks++;
        if (key_strobe !== 1'b0) begin failures++; $display("FAIL single_pulse_width: got %b expected 0", key_strobe); end
        checks++;
        if (live_value !== 16'h0005 || live_len !== 3'd1) begin
            failures++; $display("FAIL single_live: got %h/%0d expected 0005/1", live_value, live_len);
        end
        key_code = 4'h7;
        cycles(1000);
        checks++;
        if (strobe_cnt - s0 !== 1) begin failures++; $display("FAIL single_held_strobes: got %0d expected 1", strobe_cnt - s0); end
        key_down = 1'b0;
        cycles(DC + 2);
        checks++;
        if (key_value !== 4'h5 || live_value !== 16'h0005) begin
            failures++; $display("FAIL single_held_code: got %h/%h expected 5/0005", key_value, live_value);
        end
        press(keypad_pkg::KEY_CLEAR);
    endtask

    task automatic test_edit;
        int v0;
        press(4'h1); press(4'h2); press(4'h3); press(4'hF); press(4'h4);
        checks++;
        if (live_value !== 16'h0124 || live_len !== 3'd3) begin
            failures++; $display("FAIL edit_live: got %h/%0d expected 0124/3", live_value, live_len);
        end
        v0 = valid_cycles;
        press(4'hE);
        checks++;
        if (valid_cycles - v0 !== 1) begin failures++; $display("FAIL edit_valid_cycles: got %0d expected 1", valid_cycles - v0); end
        checks++;
        if (mon_value !== 16'h0124 || mon_len !== 3'd3) begin
            failures++; $display("FAIL edit_entry: got %h/%0d expected 0124/3", mon_value, mon_len);
        end
        checks++;
        if (live_len !== 3'd0 || live_value !== 16'h0 || entry_valid !== 1'b0) begin
            failures++; $display("FAIL edit_after: got %h/%0d/%b expected 0000/0/0", live_value, live_len, entry_valid);
        end
        checks++;
        if (entry_value !== 16'h0124 || entry_len !== 3'd3) begin
            failures++; $display("FAIL edit_entry_hold: got %h/%0d expected 0124/3", entry_value, entry_len);
        end
    endtask

    task automatic test_overflow_empty;
        int v0;
        for (int i = 0; i < 5; i++) press(4'h9);
        checks++;
        if (live_value !== 16'h9999 || live_len !== 3'd4) begin
            failures++; $display("FAIL overflow_live: got %h/%0d expected 9999/4", live_value, live_len);
        end
        press(4'hC);
        checks++;
        if (live_value !== 16'h0 || live_len !== 3'd0) begin
            failures++; $display("FAIL clear_live: got %h/%0d expected 0000/0", live_value, live_len);
        end
        v0 = valid_cycles;
        press(4'hE);
        press(4'hF);
        press(4'hA);
        checks++;
        if (valid_cycles - v0 !== 0 || entry_valid !== 1'b0) begin
            failures++; $display("FAIL empty_enter_valid: got %0d/%b expected 0/0", valid_cycles - v0, entry_valid);
        end
        checks++;
        if (live_value !== 16'h0 || live_len !== 3'd0 || key_value !== 4'hA) begin
            failures++; $display("FAIL empty_ops_live: got %h/%0d/%h expected 0000/0/a", live_value, live_len, key_value);
        end
        checks++;
        if (entry_value !== 16'h0124 || entry_len !== 3'd3) begin
            failures++; $display("FAIL empty_ops_entry: got %h/%0d expected 0124/3", entry_value, entry_len);
        end
    endtask

    task automatic test_backpressure;
        int s0;
        entry_ready = 1'b0;
        press(4'h7);
        press(4'hE);
        checks++;
        if (entry_valid !== 1'b1 || entry_value !== 16'h0007 || entry_len !== 3'd1) begin
            failures++; $display("FAIL bp_commit: got %b/%h/%0d expected 1/0007/1", entry_valid, entry_value, entry_len);
        end
        s0 = strobe_cnt;
        press(4'h8);
        checks++;
        if (strobe_cnt - s0 !== 1 || key_value !== 4'h8) begin
            failures++; $display("FAIL bp_strobe: got %0d/%h expected 1/8", strobe_cnt - s0, key_value);
        end
        checks++;
        if (entry_valid !== 1'b1 || entry_value !== 16'h0007 || live_len !== 3'd0 || live_value !== 16'h0) begin
            failures++; $display("FAIL bp_hold: got %b/%h/%0d/%h expected 1/0007/0/0000", entry_valid, entry_value, live_len, live_value);
        end
        entry_ready = 1'b1;
        cycles(1);
        checks++;
        if (entry_valid !== 1'b0 || entry_value !== 16'h0007 || entry_len !== 3'd1) begin
            failures++; $display("FAIL bp_accept: got %b/%h/%0d expected 0/0007/1", entry_valid, entry_value, entry_len);
        end
    endtask

    task automatic test_reset_mid_debounce;
        int s0;
        press(4'h2);
        key_code = 4'h3;
        key_down = 1'b1;
        cycles(DC - 1);
        s0 = strobe_cnt;
        reset = 1'b1;
        cycles(1);
        checks++;
        if ({key_strobe, key_value, live_value, live_len, entry_value, entry_len, entry_valid} !== 44'h0) begin
            failures++; $display("FAIL reset_pw_outputs: got %b/%h/%h/%0d/%h/%0d/%b expected all 0",
                                 key_strobe, key_value, live_value, live_len, entry_value, entry_len, entry_valid);
        end
        reset = 1'b0;
        cycles(DC - 1);
        checks++;
        if (strobe_cnt - s0 !== 0 || key_strobe !== 1'b0) begin
            failures++; $display("FAIL reset_pw_nostrobe: got %0d/%b expected 0/0", strobe_cnt - s0, key_strobe);
        end
        cycles(1);
        checks++;
        if (key_strobe !== 1'b1 || key_value !== 4'h3) begin
            failures++; $display("FAIL reset_pw_newpress: got %b/%h expected 1/3", key_strobe, key_value);
        end
        key_down = 1'b0;
        cycles(DC + 2);
        checks++;
        if (live_value !== 16'h0003 || live_len !== 3'd1) begin
            failures++; $display("FAIL reset_pw_live: got %h/%0d expected 0003/1", live_value, live_len);
        end
    endtask

    task automatic test_reset_mid_handshake;
        int s0;
        int v0;
        entry_ready = 1'b0;
        press(4'h6);
        press(4'hE);
        checks++;
        if (entry_valid !== 1'b1 || entry_value !== 16'h0036 || entry_len !== 3'd2) begin
            failures++; $display("FAIL rh_commit: got %b/%h/%0d expected 1/0036/2", entry_valid, entry_value, entry_len);
        end
        reset = 1'b1;
        cycles(1);
        checks++;
        if ({key_strobe, key_value, live_value, live_len, entry_value, entry_len, entry_valid} !== 44'h0) begin
            failures++; $display("FAIL rh_outputs: got %b/%h/%h/%0d/%h/%0d/%b expected all 0",
                                 key_strobe, key_value, live_value, live_len, entry_value, entry_len, entry_valid);
        end
        s0 = strobe_cnt;
        v0 = valid_cycles;
        reset = 1'b0;
        entry_ready = 1'b1;
        cycles(DC + 2);
        checks++;
        if (strobe_cnt - s0 !== 0 || valid_cycles - v0 !== 0 || entry_valid !== 1'b0) begin
            failures++; $display("FAIL rh_idle: got %0d/%0d/%b expected 0/0/0", strobe_cnt - s0, valid_cycles - v0, entry_valid);
        end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_single_press();
        test_edit();
        test_overflow_empty();
        test_backpressure();
        test_reset_mid_debounce();
        test_reset_mid_handshake();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
